regfile_dump: RTL



---
 rtl/regfile_dump_pkg.sv | 31 +++
 rtl/regfile_dump_hex_to_ascii.sv | 13 +
 rtl/regfile_dump.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared constants for the register-file dump engine.
// REGDUMP_INDEX_EN selects the "xNN:" line prefix.
package regfile_dump_pkg;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_X     = 8'h78;
   localparam logic [7:0] ASCII_COLON = 8'h3A;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LATCH = 2'd1;
   localparam logic [1:0] ST_EMIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      LATCH = ST_LATCH,
      EMIT  = ST_EMIT,
      DONE  = ST_DONE
   } state_t;

`ifdef REGDUMP_INDEX_EN
   localparam int PFX_LEN = 4;
`else
   localparam int PFX_LEN = 0;
`endif

   localparam int         LINE_LEN  = PFX_LEN + 10;
   localparam logic [3:0] LAST_CHAR = 4'(LINE_LEN - 1);

endpackage

// File: rtl/regfile_dump_hex_to_ascii.sv
// Nibble to uppercase hex ASCII digit.
// Also used for decimal digits 0..9 of the index prefix.
module hex_to_ascii (
   input  logic [3:0] i_nibble,
   output logic [7:0] o_ascii
);

   always_comb begin
      if (i_nibble < 4'd10) o_ascii = 8'h30 + {4'd0, i_nibble};
      else                  o_ascii = 8'h37 + {4'd0, i_nibble};
   end

endmodule

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks the debug read port and streams
// hex text lines; REGDUMP_INDEX_EN adds an "xNN:" prefix per line.
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_done,
   output logic [4:0]  o_reg_debug_address,
   input  logic [31:0] i_reg_debug_data,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready
);

   localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
   localparam logic [4:0] LAST_A  = 5'(LAST_REG);

   state_t      r_state;
   logic [4:0]  r_addr;
   logic [3:0]  r_idx;
   logic [31:0] r_snap;
   logic        r_busy;
   logic        r_done;
   logic        r_valid;

   logic        w_hs;
   logic        w_last_char;
   logic [2:0]  w_pos;
   logic [3:0]  w_nib;
   logic [7:0]  w_hex;
   logic [7:0]  w_char;

   assign w_hs        = r_valid & i_tx_ready;
   assign w_last_char = (r_idx == LAST_CHAR);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_addr  <= FIRST_A;
         r_idx   <= 4'd0;
         r_snap  <= 32'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state <= LATCH;
                  r_addr  <= FIRST_A;
                  r_busy  <= 1'b1;
               end
            end
            LATCH: begin
               r_snap  <= i_reg_debug_data;
               r_idx   <= 4'd0;
               r_valid <= 1'b1;
               r_state <= EMIT;
            end
            EMIT: begin
               if (w_hs) begin
                  if (!w_last_char) begin
                     r_idx <= r_idx + 4'd1;
                  end else begin
                     r_valid <= 1'b0;
                     if (r_addr == LAST_A) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_addr  <= r_addr + 5'd1;
                        r_state <= LATCH;
                     end
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_addr  <= FIRST_A;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef REGDUMP_INDEX_EN
   logic [3:0] w_tens;
   logic [3:0] w_ones;

   always_comb begin
      if (r_addr >= 5'd30)      w_tens = 4'd3;
      else if (r_addr >= 5'd20) w_tens = 4'd2;
      else if (r_addr >= 5'd10) w_tens = 4'd1;
      else                      w_tens = 4'd0;
      w_ones = 4'(r_addr - {1'b0, w_tens} * 5'd10);
   end

   assign w_pos = 3'(r_idx - 4'd4);

   // Index digits share the single hex converter with the data nibbles.
   always_comb begin
      w_nib = 4'(r_snap >> {3'd7 - w_pos, 2'b00});
      if (r_idx == 4'd1)      w_nib = w_tens;
      else if (r_idx == 4'd2) w_nib = w_ones;
   end
`else
   assign w_pos = r_idx[2:0];

   always_comb begin
      w_nib = 4'(r_snap >> {3'd7 - w_pos, 2'b00});
   end
`endif

   hex_to_ascii u_hex (
      .i_nibble (w_nib),
      .o_ascii  (w_hex)
   );

   always_comb begin
      w_char = w_hex;
      unique case (1'b1)
         (r_idx == LAST_CHAR):         w_char = ASCII_LF;
         (r_idx == LAST_CHAR - 4'd1):  w_char = ASCII_CR;
`ifdef REGDUMP_INDEX_EN
         (r_idx == 4'd0):              w_char = ASCII_X;
         (r_idx == 4'd3):              w_char = ASCII_COLON;
`endif
         default:                      w_char = w_hex;
      endcase
   end

   assign o_tx_data           = r_valid ? w_char : 8'h00;
   assign o_tx_valid          = r_valid;
   assign o_busy              = r_busy;
   assign o_done              = r_done;
   assign o_reg_debug_address = r_addr;

endmodule
